// File: rtl/esn_pkg.sv
// esn_pkg: shared mode/state types, LFSR taps and Q-format helpers for the ESN streaming source
package esn_pkg;
  typedef enum logic {ESN_READOUT = 1'b0, ESN_STATE = 1'b1} esn_mode_e;
  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_MAC, S_PUSH} esn_state_e;
  typedef logic signed [127:0] wide_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic wide_t q_one(input int frac);
    return wide_t'(1) <<< frac;
  endfunction
  function automatic wide_t clip_q(input wide_t v, input int frac);
    return v > q_one(frac) ? q_one(frac) : v < -q_one(frac) ? -q_one(frac) : v;
  endfunction
  function automatic wide_t sat_w(input wide_t v, input int w);
    wide_t m;
    m = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    return v > m ? m : v < -m ? -m : v;
  endfunction
endpackage

// File: rtl/esn_st_fifo.sv
// esn_st_fifo: show-ahead synchronous FIFO reporting its free word count
module esn_st_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   free
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  assign do_pop = pop && cnt != '0;
  assign do_push = push && cnt != CW'(DEPTH);
  always_ff @(posedge clk)
    if (reset) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr == AW'(DEPTH - 1) ? '0 : wr + 1'b1;
      if (do_pop) rd <= rd == AW'(DEPTH - 1) ? '0 : rd + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  assign valid = cnt != '0;
  assign dout = valid ? mem[rd] : '0;
  assign free = CW'(DEPTH) - cnt;
endmodule

// File: rtl/esn_st_src_par.sv
// esn_st_src_par: LFSR-driven ring reservoir streaming readout/state words over ready/valid
module esn_st_src_par
  import esn_pkg::*;
#(
  parameter int                         DATA_W     = 32,
  parameter int                         FRAC       = 16,
  parameter int                         N_NODES    = 8,
  parameter int                         FIFO_DEPTH = 16,
  parameter logic signed [DATA_W-1:0]   R_WEIGHT   = 'sh0000_E666,
  parameter logic signed [DATA_W-1:0]   V_WEIGHT   = 'sh0000_8000,
  parameter logic [15:0]                LFSR_SEED  = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         mode,
  input  logic                         wout_we,
  input  logic [$clog2(N_NODES)-1:0]   wout_addr,
  input  logic signed [DATA_W-1:0]     wout_data,
  input  logic                         data_ready,
  output logic                         data_valid,
  output logic [DATA_W-1:0]            data_out,
  output logic                         data_sop,
  output logic                         data_eop,
  output logic                         busy,
  output logic [15:0]                  step_count
);
  localparam int AW = $clog2(N_NODES);
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam int ACC_W = 2 * DATA_W + AW;
  if (FIFO_DEPTH < N_NODES + 1) begin : g_depth_chk
    $error("FIFO_DEPTH must be at least N_NODES+1");
  end
  esn_state_e state, state_nxt;
  esn_mode_e mode_q;
  logic signed [DATA_W-1:0] x [N_NODES];
  logic signed [DATA_W-1:0] x_nxt [N_NODES];
  logic signed [DATA_W-1:0] wout [N_NODES];
  logic signed [DATA_W-1:0] u, y;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0] acc;
  logic [AW-1:0] k;
  logic [15:0] lfsr;
  logic [FW-1:0] free, need;
  logic push, sop_in, eop_in;
  logic [DATA_W-1:0] din;
  logic [DATA_W+1:0] head;
  assign u = lfsr[0] ? V_WEIGHT : -V_WEIGHT;
  for (genvar i = 0; i < N_NODES; i++) begin : g_node
    logic signed [2*DATA_W-1:0] rp;
    assign rp = R_WEIGHT * x[(i + N_NODES - 1) % N_NODES];
    assign x_nxt[i] = DATA_W'(clip_q(wide_t'(rp >>> FRAC) + wide_t'(u), FRAC));
  end
  assign prod = wout[k] * x[k];
  assign y = DATA_W'(sat_w(wide_t'(acc >>> FRAC), DATA_W));
  assign need = mode ? FW'(N_NODES + 1) : FW'(1);
  always_ff @(posedge clk) state <= reset ? S_IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = enable && free >= need ? S_UPDATE : S_IDLE;
      S_UPDATE: state_nxt = S_MAC;
      S_MAC:    state_nxt = k == AW'(N_NODES - 1) ? S_PUSH : S_MAC;
      default:  state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      for (int j = 0; j < N_NODES; j++) begin
        x[j] <= '0;
        wout[j] <= '0;
      end
      lfsr <= LFSR_SEED;
      acc <= '0;
      k <= '0;
      mode_q <= ESN_READOUT;
      step_count <= '0;
    end else begin
      if (wout_we) wout[wout_addr] <= wout_data;
      if (state == S_IDLE) mode_q <= esn_mode_e'(mode);
      if (state == S_UPDATE) begin
        x <= x_nxt;
        lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        acc <= '0;
        k <= '0;
      end
      if (state == S_MAC) begin
        acc <= acc + ACC_W'(prod);
        k <= k + 1'b1;
      end
      if (state == S_PUSH) step_count <= step_count + 1'b1;
    end
  assign push = state == S_PUSH || (state == S_MAC && mode_q == ESN_STATE);
  assign din = state == S_PUSH ? y : x[k];
  assign sop_in = state == S_PUSH ? mode_q == ESN_READOUT : k == '0;
  assign eop_in = state == S_PUSH;
  esn_st_fifo #(.WIDTH(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din({sop_in, eop_in, din}),
    .pop(data_ready),
    .dout(head),
    .valid(data_valid),
    .free(free)
  );
  assign {data_sop, data_eop, data_out} = head;
  assign busy = state != S_IDLE;
endmodule

// File: tb/tb_esn_st_src_par.sv
// tb_esn_st_src_par: directed self-checking bench for the ESN streaming source
module tb_esn_st_src_par;
  logic clk = 0, reset = 1, enable = 0, mode = 0, wout_we = 0, data_ready = 0;
  logic [1:0] wout_addr = 0;
  logic [31:0] wout_data = 0;
  logic data_valid, data_sop, data_eop, busy;
  logic [31:0] data_out;
  logic [15:0] step_count;
  logic enable_b = 0, mode_b = 1, ready_b = 1;
  logic valid_b, sop_b, eop_b, busy_b;
  logic [31:0] out_b;
  logic [15:0] count_b;
  int n_vec = 0, n_bad = 0;
  logic [33:0] q[$], qb[$];
  logic [31:0] exp_y [9] = '{32'h0002_0000, 32'hFFFF_0000, 32'hFFFD_8000, 32'hFFFC_C000,
                            32'hFFFC_6000, 32'hFFFC_3000, 32'hFFFC_1800, 32'hFFFC_0C00,
                            32'hFFFC_0600};
  always #5 clk = ~clk;
  esn_st_src_par #(.DATA_W(32), .FRAC(16), .N_NODES(4), .FIFO_DEPTH(8),
    .R_WEIGHT(32'sh0000_8000), .V_WEIGHT(32'sh0000_8000), .LFSR_SEED(16'h0001)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .wout_we(wout_we),
    .wout_addr(wout_addr), .wout_data(wout_data), .data_ready(data_ready),
    .data_valid(data_valid), .data_out(data_out), .data_sop(data_sop),
    .data_eop(data_eop), .busy(busy), .step_count(step_count));
  esn_st_src_par #(.DATA_W(32), .FRAC(16), .N_NODES(4), .FIFO_DEPTH(8),
    .R_WEIGHT(32'sh0001_8000), .V_WEIGHT(32'sh0001_0000), .LFSR_SEED(16'h0401)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .mode(mode_b), .wout_we(wout_we),
    .wout_addr(wout_addr), .wout_data(wout_data), .data_ready(ready_b),
    .data_valid(valid_b), .data_out(out_b), .data_sop(sop_b),
    .data_eop(eop_b), .busy(busy_b), .step_count(count_b));
  always @(negedge clk) begin
    if (!reset && data_valid && data_ready) q.push_back({data_sop, data_eop, data_out});
    if (!reset && valid_b && ready_b) qb.push_back({sop_b, eop_b, out_b});
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1;
    enable = 0;
    enable_b = 0;
    data_ready = 0;
    mode = 0;
    tick(2);
    reset = 0;
    q.delete();
    qb.delete();
  endtask
  task automatic load_w(input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      wout_we = 1;
      wout_addr = 2'(i);
      wout_data = v;
      tick(1);
    end
    wout_we = 0;
  endtask
  task automatic wait_q(input bit sel, input int n, input int budget, input bit tog);
    int c = 0;
    while ((sel ? qb.size() : q.size()) < n && c < budget) begin
      tick(1);
      if (tog) data_ready = ~data_ready;
      c++;
    end
    if ((sel ? qb.size() : q.size()) < n) chk("timeout", 64'(sel ? qb.size() : q.size()), 64'(n));
  endtask
  initial begin
    do_reset();
    enable = 1;
    chk("rst_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out", data_out, 0);
    chk("rst_sop", data_sop, 0);
    chk("rst_eop", data_eop, 0);
    chk("rst_count", step_count, 0);
    tick(6);
    chk("t1_c6_valid", data_valid, 0);
    chk("t1_c6_busy", busy, 1);
    tick(1);
    chk("t1_c7_valid", data_valid, 1);
    chk("t1_c7_out", data_out, 0);
    chk("t1_c7_sop", data_sop, 1);
    chk("t1_c7_eop", data_eop, 1);
    do_reset();
    load_w(32'h0001_0000);
    data_ready = 1;
    enable = 1;
    tick(1);
    enable = 0;
    wait_q(0, 1, 30, 0);
    chk("t2_y", q[0][31:0], 32'h0002_0000);
    chk("t2_sop_eop", q[0][33:32], 2'b11);
    chk("t2_count", step_count, 1);
    do_reset();
    load_w(32'h0001_0000);
    mode = 1;
    data_ready = 1;
    enable = 1;
    tick(1);
    enable = 0;
    wait_q(0, 5, 40, 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_w%0d", i), q[i][31:0], i < 4 ? 32'h8000 : 32'h0002_0000);
      chk($sformatf("t3_sop%0d", i), q[i][33], i == 0);
      chk($sformatf("t3_eop%0d", i), q[i][32], i == 4);
    end
    do_reset();
    load_w(32'h0001_0000);
    enable = 1;
    tick(100);
    chk("t5_full_busy", busy, 0);
    chk("t5_full_count", step_count, 8);
    chk("t5_full_valid", data_valid, 1);
    chk("t5_hold_out", data_out, 32'h0002_0000);
    tick(3);
    chk("t5_hold_out2", data_out, 32'h0002_0000);
    chk("t5_hold_sop", data_sop, 1);
    chk("t5_hold_eop", data_eop, 1);
    data_ready = 1;
    wait_q(0, 9, 100, 0);
    enable = 0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t5_y%0d", i), q[i][31:0], exp_y[i]);
      chk($sformatf("t5_fr%0d", i), q[i][33:32], 2'b11);
    end
    do_reset();
    load_w(32'h0001_0000);
    enable = 1;
    wait_q(0, 9, 300, 1);
    enable = 0;
    for (int i = 0; i < 9; i++) chk($sformatf("t5t_y%0d", i), q[i][31:0], exp_y[i]);
    do_reset();
    load_w(32'h0001_0000);
    enable = 1;
    tick(11);
    chk("t6_pre_busy", busy, 1);
    chk("t6_pre_valid", data_valid, 1);
    chk("t6_pre_count", step_count, 1);
    reset = 1;
    tick(1);
    reset = 0;
    chk("t6_valid", data_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_count", step_count, 0);
    tick(6);
    chk("t6_re_c6_valid", data_valid, 0);
    tick(1);
    chk("t6_re_valid", data_valid, 1);
    chk("t6_re_out", data_out, 0);
    chk("t6_re_count", step_count, 1);
    do_reset();
    load_w(32'h7FFF_FFFF);
    enable_b = 1;
    wait_q(1, 10, 60, 0);
    enable_b = 0;
    for (int i = 0; i < 10; i++)
      chk($sformatf("t4_w%0d", i), qb[i][31:0], i % 5 < 4 ? 32'h0001_0000 : 32'h7FFF_FFFF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
